// File: rtl/control_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : control_multicycle
// Brief    : Multicycle MIPS main control FSM. It has a ready-based memory
//            handshake, a wait watchdog, an optional jump and a sticky trap.
// Revision : 1.0 - initial release
// ============================================================================
module control_multicycle #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] cause
);

  // The counter keeps at least one bit so that MEM_TIMEOUT=0 (watchdog off)
  // still elaborates.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit             c_wd_en    = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0]  c_cnt_last = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  localparam logic [1:0] c_cause_none    = 2'b00;
  localparam logic [1:0] c_cause_illegal = 2'b01;
  localparam logic [1:0] c_cause_timeout = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [5:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic [1:0]    w_cause_next;
  logic          w_in_mem;
  logic          w_next_mem;
  logic          w_expire;

  assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_next_mem = (w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR);
  assign w_expire   = c_wd_en && (r_cnt == c_cnt_last) && !mem_ready;

  // State, latched opcode, watchdog counter and fault cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_op    <= 6'd0;
      r_cnt   <= '0;
      r_cause <= c_cause_none;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (r_state == S_DECODE) begin
        r_op <= opcode;
      end
      if (w_next_mem && (w_next != r_state)) begin
        r_cnt <= '0;
      end else if (w_in_mem && !mem_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next-state selection and per-state datapath controls; everything is
  // forced low while reset is asserted.
  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    pcwrite      = 1'b0;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsource     = 2'b00;
    instr_done   = 1'b0;
    trap         = 1'b0;
    cause        = 2'b00;
    if (!rst) begin
      cause = r_cause;
      case (r_state)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            w_next  = S_DECODE;
          end else if (w_expire) begin
            w_next       = S_TRAP;
            w_cause_next = c_cause_timeout;
          end
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (opcode)
            c_op_lw, c_op_sw:   w_next = S_MEMADR;
            c_op_rtype:         w_next = S_EXEC;
            c_op_addi:          w_next = S_IEXEC;
            c_op_beq, c_op_bne: w_next = S_BRANCH;
            c_op_j: begin
              if (ENABLE_JUMP) begin
                w_next = S_JUMP;
              end else begin
                w_next       = S_TRAP;
                w_cause_next = c_cause_illegal;
              end
            end
            default: begin
              w_next       = S_TRAP;
              w_cause_next = c_cause_illegal;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          w_next  = (r_op == c_op_sw) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            w_next = S_MEMWB;
          end else if (w_expire) begin
            w_next       = S_TRAP;
            w_cause_next = c_cause_timeout;
          end
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else if (w_expire) begin
            w_next       = S_TRAP;
            w_cause_next = c_cause_timeout;
          end
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
          w_next  = S_RWB;
        end
        S_RWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_IEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          w_next  = S_IWB;
        end
        S_IWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          aluop      = 2'b01;
          pcsource   = 2'b01;
          instr_done = 1'b1;
          pcwrite    = ((r_op == c_op_beq) && zero) || ((r_op == c_op_bne) && !zero);
          w_next     = S_FETCH;
        end
        S_JUMP: begin
          pcsource   = 2'b10;
          pcwrite    = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_TRAP: begin
          trap   = 1'b1;
          w_next = S_TRAP;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
